// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// Holds the FSM encoding, default bus widths and the requester port indices.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam int ADDR_W_DEF = 24;
  localparam int DATA_W_DEF = 16;
  localparam int CNT_W      = 4;

  localparam logic PORT_CORE = 1'b0;
  localparam logic PORT_VGA  = 1'b1;

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// Round-robin choice between two requesters; purely combinational.
// A tie goes to the port that did not win last time.
module rr_picker
  import mem_arbiter_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_gnt,
  output logic pick_valid,
  output logic pick
);

  always_comb begin
    pick_valid = req0 | req1;
    if (req0 && req1) begin
      pick = ~last_gnt;
    end else if (req1) begin
      pick = PORT_VGA;
    end else begin
      pick = PORT_CORE;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory channel between core (port 0) and VGA fetch (port 1), one transaction at a time.
// Ack arrives MEM_LATENCY+2 cycles after the request is sampled; requesters simply wait on req/ack.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int MEM_LATENCY = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              ack0,
  output logic              ack1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

  state_t            state;
  state_t            state_nxt;
  logic              owner;
  logic              last_gnt;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [CNT_W-1:0]  cnt;
  logic              pick_valid;
  logic              pick;

  rr_picker u_picker (
    .req0       (req0),
    .req1       (req1),
    .last_gnt   (last_gnt),
    .pick_valid (pick_valid),
    .pick       (pick)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_valid) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (cnt == '0) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request fields are frozen at grant so requesters may change inputs freely while in flight.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      owner     <= PORT_CORE;
      last_gnt  <= PORT_VGA;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      cnt       <= '0;
      rdata0    <= '0;
      rdata1    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            owner     <= pick;
            last_gnt  <= pick;
            lat_we    <= (pick == PORT_VGA) ? we1 : we0;
            lat_addr  <= (pick == PORT_VGA) ? addr1 : addr0;
            lat_wdata <= (pick == PORT_VGA) ? wdata1 : wdata0;
          end
        end
        ISSUE: cnt <= CNT_LOAD;
        WAIT: begin
          if (cnt == '0) begin
            if (!lat_we) begin
              if (owner == PORT_VGA) rdata1 <= mem_rdata;
              else                   rdata0 <= mem_rdata;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy      = (state != IDLE);
    mem_req   = (state == ISSUE);
    mem_we    = mem_req & lat_we;
    mem_addr  = mem_req ? lat_addr : '0;
    mem_wdata = mem_req ? lat_wdata : '0;
    gnt0      = busy && (owner == PORT_CORE);
    gnt1      = busy && (owner == PORT_VGA);
    ack0      = (state == RESP) && (owner == PORT_CORE);
    ack1      = (state == RESP) && (owner == PORT_VGA);
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench: directed table, multi-cycle corner sequences and a randomized phase
// against a transaction-level model; a second build with MEM_LATENCY=1 is selected via sel_b.
module tb_mem_arbiter;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [23:0] addr0 = '0, addr1 = '0;
  logic [15:0] wdata0 = '0, wdata1 = '0;
  logic        sel_b = 1'b0;
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;

  wire a_req0 = req0 & ~sel_b;
  wire a_req1 = req1 & ~sel_b;
  wire b_req0 = req0 & sel_b;
  wire b_req1 = req1 & sel_b;

  logic [15:0] a_rdata0, a_rdata1, a_mem_wdata, a_mem_rdata;
  logic        a_ack0, a_ack1, a_gnt0, a_gnt1, a_mem_req, a_mem_we, a_busy;
  logic [23:0] a_mem_addr;
  logic [15:0] b_rdata0, b_rdata1, b_mem_wdata, b_mem_rdata;
  logic        b_ack0, b_ack1, b_gnt0, b_gnt1, b_mem_req, b_mem_we, b_busy;
  logic [23:0] b_mem_addr;

  mem_arbiter #(.ADDR_W(24), .DATA_W(16), .MEM_LATENCY(2)) dut_a (
    .clock(clock), .reset_n(reset_n), .req0(a_req0), .req1(a_req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .rdata0(a_rdata0), .rdata1(a_rdata1), .ack0(a_ack0), .ack1(a_ack1),
    .gnt0(a_gnt0), .gnt1(a_gnt1), .mem_req(a_mem_req), .mem_we(a_mem_we),
    .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata), .busy(a_busy)
  );

  mem_arbiter #(.ADDR_W(24), .DATA_W(16), .MEM_LATENCY(1)) dut_b (
    .clock(clock), .reset_n(reset_n), .req0(b_req0), .req1(b_req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .rdata0(b_rdata0), .rdata1(b_rdata1), .ack0(b_ack0), .ack1(b_ack1),
    .gnt0(b_gnt0), .gnt1(b_gnt1), .mem_req(b_mem_req), .mem_we(b_mem_we),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .busy(b_busy)
  );

  wire [15:0] o_rdata0    = sel_b ? b_rdata0 : a_rdata0;
  wire [15:0] o_rdata1    = sel_b ? b_rdata1 : a_rdata1;
  wire        o_ack0      = sel_b ? b_ack0 : a_ack0;
  wire        o_ack1      = sel_b ? b_ack1 : a_ack1;
  wire        o_gnt0      = sel_b ? b_gnt0 : a_gnt0;
  wire        o_gnt1      = sel_b ? b_gnt1 : a_gnt1;
  wire        o_mem_req   = sel_b ? b_mem_req : a_mem_req;
  wire        o_mem_we    = sel_b ? b_mem_we : a_mem_we;
  wire [23:0] o_mem_addr  = sel_b ? b_mem_addr : a_mem_addr;
  wire [15:0] o_mem_wdata = sel_b ? b_mem_wdata : a_mem_wdata;
  wire        o_busy      = sel_b ? b_busy : a_busy;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [15:0] init_val(input logic [7:0] a);
    return (a == 8'h10) ? 16'hBEEF : {8'hA5, a};
  endfunction

  // Memory stand-ins: read data is only valid in the single cycle MEM_LATENCY after mem_req.
  logic [15:0] mem_a [256];
  bit          wr_a [256];
  int          dly_a = 0;
  logic [15:0] dat_a = '0;
  always @(posedge clock) begin
    if (a_mem_req) begin
      if (a_mem_we) begin
        mem_a[a_mem_addr[7:0]] <= a_mem_wdata;
        wr_a[a_mem_addr[7:0]]  <= 1'b1;
      end
      dat_a <= wr_a[a_mem_addr[7:0]] ? mem_a[a_mem_addr[7:0]] : init_val(a_mem_addr[7:0]);
      dly_a <= 2;
    end else if (dly_a != 0) begin
      dly_a <= dly_a - 1;
    end
  end
  assign a_mem_rdata = (dly_a == 1) ? dat_a : 16'hDEAD;

  logic [15:0] mem_b [256];
  bit          wr_b [256];
  int          dly_b = 0;
  logic [15:0] dat_b = '0;
  always @(posedge clock) begin
    if (b_mem_req) begin
      if (b_mem_we) begin
        mem_b[b_mem_addr[7:0]] <= b_mem_wdata;
        wr_b[b_mem_addr[7:0]]  <= 1'b1;
      end
      dat_b <= wr_b[b_mem_addr[7:0]] ? mem_b[b_mem_addr[7:0]] : init_val(b_mem_addr[7:0]);
      dly_b <= 1;
    end else if (dly_b != 0) begin
      dly_b <= dly_b - 1;
    end
  end
  assign b_mem_rdata = (dly_b == 1) ? dat_b : 16'hDEAD;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] outs_a();
    return 128'({a_rdata0, a_rdata1, a_ack0, a_ack1, a_gnt0, a_gnt1, a_mem_req, a_mem_we,
                 a_mem_addr, a_mem_wdata, a_busy});
  endfunction

  function automatic logic [127:0] outs_b();
    return 128'({b_rdata0, b_rdata1, b_ack0, b_ack1, b_gnt0, b_gnt1, b_mem_req, b_mem_we,
                 b_mem_addr, b_mem_wdata, b_busy});
  endfunction

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    req0 = 1'b0;
    req1 = 1'b0;
    @(negedge clock);
    chk("reset_state_a", outs_a(), 128'(0));
    chk("reset_state_b", outs_b(), 128'(0));
    reset_n = 1'b1;
  endtask

  // One request pattern through to ack; checks issue/ack timing, channel fields, grants and data.
  task automatic run_txn(input string nm, input logic r0, input logic r1, input logic w0,
                         input logic w1, input logic [23:0] a0, input logic [23:0] a1,
                         input logic [15:0] d0, input logic [15:0] d1, input int port,
                         input logic [15:0] exp_rd);
    int          lat, t, req_c, ack_c, ack_p, nreq;
    logic [23:0] m_addr;
    logic        m_we;
    logic [15:0] m_wd, rd, oth_before, oth_after;
    lat = sel_b ? 1 : 2;
    req_c = -1; ack_c = -1; ack_p = -1; nreq = 0;
    m_addr = '0; m_we = 1'b0; m_wd = '0; rd = '0;
    @(negedge clock);
    chk({nm, " idle_before"}, 128'(o_busy), 128'(0));
    oth_before = (port == 0) ? o_rdata1 : o_rdata0;
    req0 = r0; req1 = r1; we0 = w0; we1 = w1;
    addr0 = a0; addr1 = a1; wdata0 = d0; wdata1 = d1;
    t = cyc;
    for (int i = 0; i < 24 && ack_c < 0; i++) begin
      @(negedge clock);
      if (o_mem_req) begin
        nreq++;
        req_c = cyc; m_addr = o_mem_addr; m_we = o_mem_we; m_wd = o_mem_wdata;
      end else begin
        chk({nm, " mem_idle_zero"}, 128'({o_mem_we, o_mem_addr, o_mem_wdata}), 128'(0));
      end
      chk({nm, " gnt"}, 128'({o_gnt1, o_gnt0}), 128'((port == 0) ? 2'b01 : 2'b10));
      if (o_ack0 || o_ack1) begin
        ack_c = cyc;
        ack_p = (o_ack0 && o_ack1) ? 2 : (o_ack1 ? 1 : 0);
        rd = o_ack1 ? o_rdata1 : o_rdata0;
        req0 = 1'b0;
        req1 = 1'b0;
      end
    end
    req0 = 1'b0;
    req1 = 1'b0;
    chk({nm, " ack_port"}, 128'(ack_p), 128'(port));
    chk({nm, " ack_cycle"}, 128'(ack_c), 128'(t + 2 + lat));
    chk({nm, " req_cycle"}, 128'(req_c), 128'(t + 1));
    chk({nm, " req_count"}, 128'(nreq), 128'(1));
    chk({nm, " mem_addr"}, 128'(m_addr), 128'((port == 1) ? a1 : a0));
    chk({nm, " mem_we"}, 128'(m_we), 128'((port == 1) ? w1 : w0));
    chk({nm, " mem_wdata"}, 128'(m_wd), 128'((port == 1) ? d1 : d0));
    chk({nm, " rdata"}, 128'(rd), 128'(exp_rd));
    @(negedge clock);
    oth_after = (port == 0) ? o_rdata1 : o_rdata0;
    chk({nm, " other_rdata_kept"}, 128'(oth_after), 128'(oth_before));
    chk({nm, " idle_after"}, 128'({o_busy, o_gnt1, o_gnt0, o_ack1, o_ack0}), 128'(0));
  endtask

  typedef struct {
    string       nm;
    logic        r0, r1, w0, w1;
    logic [23:0] a0, a1;
    logic [15:0] d0, d1;
    int          port;
    logic [15:0] rd;
  } vec_t;

  vec_t        vecs [5];
  int          ports [4];
  int          cycs [4];
  logic [15:0] rds [4];
  logic [23:0] maddr [2];
  int          mcyc [2];
  int          n, nack, t0, pat, win;
  logic        r0, r1, w0, w1, ref_last, wwe;
  logic [23:0] a0, a1, wa;
  logic [15:0] d0, d1, exp_rd;
  logic [15:0] ref_mem [256];
  bit          ref_wr [256];
  logic [15:0] ref_rd [2];

  initial begin
    vecs[0] = '{"rd_p0",    1, 0, 0, 0, 24'h000010, 24'h0, 16'h0000, 16'h0,    0, 16'hBEEF};
    vecs[1] = '{"wr_p1",    0, 1, 0, 1, 24'h0,      24'h0000FF, 16'h0,  16'h1234, 1, 16'h0000};
    vecs[2] = '{"rd_p1",    0, 1, 0, 0, 24'h0,      24'h0000FF, 16'h0,  16'h0,    1, 16'h1234};
    vecs[3] = '{"wr_p0",    1, 0, 1, 0, 24'h000010, 24'h0, 16'h5555, 16'h0,    0, 16'hBEEF};
    vecs[4] = '{"rd_p0_b",  1, 0, 0, 0, 24'h000010, 24'h0, 16'h7777, 16'h0,    0, 16'h5555};

    do_reset();
    for (int i = 0; i < 5; i++)
      run_txn(vecs[i].nm, vecs[i].r0, vecs[i].r1, vecs[i].w0, vecs[i].w1, vecs[i].a0,
              vecs[i].a1, vecs[i].d0, vecs[i].d1, vecs[i].port, vecs[i].rd);
    sel_b = 1'b1;
    for (int i = 0; i < 5; i++)
      run_txn({"lat1_", vecs[i].nm}, vecs[i].r0, vecs[i].r1, vecs[i].w0, vecs[i].w1,
              vecs[i].a0, vecs[i].a1, vecs[i].d0, vecs[i].d1, vecs[i].port, vecs[i].rd);
    sel_b = 1'b0;

    // Contention from reset: strict alternation starting with port 0, back-to-back every 5 cycles.
    do_reset();
    for (int k = 0; k < 4; k++) begin ports[k] = -1; cycs[k] = -1; rds[k] = '0; end
    @(negedge clock);
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0; addr0 = 24'h30; addr1 = 24'h31;
    t0 = cyc;
    n = 0;
    for (int i = 0; i < 40 && n < 4; i++) begin
      @(negedge clock);
      if (o_ack0 || o_ack1) begin
        ports[n] = o_ack1 ? 1 : 0;
        cycs[n] = cyc;
        rds[n] = o_ack1 ? o_rdata1 : o_rdata0;
        n++;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    chk("contend first_ack", 128'(cycs[0]), 128'(t0 + 4));
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("contend order%0d", k), 128'(ports[k]), 128'(k % 2));
      chk($sformatf("contend rdata%0d", k), 128'(rds[k]), 128'(init_val((k % 2 == 1) ? 8'h31 : 8'h30)));
      if (k > 0) chk($sformatf("contend spacing%0d", k), 128'(cycs[k] - cycs[k-1]), 128'(5));
    end

    // Address changed during WAIT must not leak into the in-flight transaction.
    @(negedge clock);
    @(negedge clock);
    req0 = 1'b1; we0 = 1'b0; addr0 = 24'h10; req1 = 1'b0;
    t0 = cyc;
    n = 0; nack = 0;
    maddr[0] = '0; maddr[1] = '0; mcyc[0] = -1; mcyc[1] = -1;
    for (int i = 0; i < 40 && nack < 2; i++) begin
      @(negedge clock);
      if (cyc == t0 + 2) addr0 = 24'h20;
      if (o_mem_req && n < 2) begin maddr[n] = o_mem_addr; mcyc[n] = cyc; n++; end
      if (o_ack0) begin nack++; if (nack == 2) req0 = 1'b0; end
    end
    req0 = 1'b0;
    chk("inflight addr1", 128'(maddr[0]), 128'(24'h10));
    chk("inflight addr2", 128'(maddr[1]), 128'(24'h20));
    chk("inflight cyc1", 128'(mcyc[0]), 128'(t0 + 1));
    chk("inflight cyc2", 128'(mcyc[1]), 128'(t0 + 6));

    // Reset asserted while waiting on memory: outputs clear at once, no ack afterwards.
    @(negedge clock);
    @(negedge clock);
    req0 = 1'b1; we0 = 1'b0; addr0 = 24'h10;
    @(negedge clock);
    @(negedge clock);
    chk("rstmid inflight", 128'({a_busy, a_gnt0, a_mem_req}), 128'(3'b110));
    reset_n = 1'b0;
    req0 = 1'b0;
    #1;
    chk("rstmid async_a", outs_a(), 128'(0));
    chk("rstmid async_b", outs_b(), 128'(0));
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      chk("rstmid no_ack", 128'({a_ack0, a_ack1, a_busy}), 128'(0));
    end
    run_txn("rstmid tie", 1, 1, 0, 0, 24'h30, 24'h31, 16'h0, 16'h0, 0, init_val(8'h30));

    // Randomized phase against a transaction-level model.
    do_reset();
    ref_last = 1'b1;
    ref_rd[0] = '0;
    ref_rd[1] = '0;
    for (int k = 0; k < 40; k++) begin
      pat = $urandom_range(1, 3);
      r0 = pat[0]; r1 = pat[1];
      w0 = 1'($urandom_range(0, 1)); w1 = 1'($urandom_range(0, 1));
      a0 = 24'h50 + 24'($urandom_range(0, 7));
      a1 = 24'h50 + 24'($urandom_range(0, 7));
      d0 = 16'($urandom); d1 = 16'($urandom);
      win = (r0 && r1) ? (ref_last ? 0 : 1) : (r1 ? 1 : 0);
      wa  = (win == 1) ? a1 : a0;
      wwe = (win == 1) ? w1 : w0;
      if (wwe) begin
        ref_mem[wa[7:0]] = (win == 1) ? d1 : d0;
        ref_wr[wa[7:0]] = 1'b1;
        exp_rd = ref_rd[win];
      end else begin
        exp_rd = ref_wr[wa[7:0]] ? ref_mem[wa[7:0]] : init_val(wa[7:0]);
      end
      ref_rd[win] = exp_rd;
      ref_last = (win == 1);
      run_txn($sformatf("rand%0d", k), r0, r1, w0, w1, a0, a1, d0, d1, win, exp_rd);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
